// File: rtl/uart_temp_sens_pkg.sv
// Shared constants, TX state encoding and frame byte selection for the
// PWM temperature-sensor UART reporter.
package uart_temp_sens_pkg;

  localparam logic [7:0] SYNC_BYTE       = 8'hA5;
  localparam int         FRAME_BYTES     = 3;
  localparam int         COUNT_W_DEFAULT = 12;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  // Byte idx of a frame: sync, then the 12-bit value high nibble first.
  function automatic logic [7:0] frame_byte(input logic [1:0]  idx,
                                            input logic [11:0] value);
    case (idx)
      2'd0:    frame_byte = SYNC_BYTE;
      2'd1:    frame_byte = {4'b0000, value[11:8]};
      default: frame_byte = value[7:0];
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_8n1.sv
// 8N1 byte transmitter. A start request during the last stop-bit cycle
// chains straight into the next start bit, so multi-byte frames are gapless.
module uart_tx_8n1
  import uart_temp_sens_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_e      state, state_d;
  logic [CW-1:0]  clk_cnt, clk_cnt_d;
  logic [2:0]     bit_idx, bit_idx_d;
  logic [7:0]     shreg, shreg_d;
  logic           tx_d;
  logic           bit_end;

  assign bit_end = (clk_cnt == LAST);
  assign busy    = (state != IDLE);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
    state_d   = state;
    clk_cnt_d = bit_end ? '0 : clk_cnt + 1'b1;
    bit_idx_d = bit_idx;
    shreg_d   = shreg;
    done      = 1'b0;
    case (state)
      IDLE: begin
        clk_cnt_d = '0;
        if (start) begin
          state_d = START;
          shreg_d = data;
        end
      end
      START: if (bit_end) begin
        state_d   = DATA;
        bit_idx_d = 3'd0;
      end
      DATA: if (bit_end) begin
        shreg_d = {1'b0, shreg[7:1]};
        if (bit_idx == 3'd7) state_d = STOP;
        else                 bit_idx_d = bit_idx + 3'd1;
      end
      STOP: if (bit_end) begin
        done = 1'b1;
        if (start) begin
          state_d = START;
          shreg_d = data;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level is registered from the next state so the pin never glitches.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    if (rst) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_idx <= 3'd0;
      shreg   <= 8'h00;
      tx      <= 1'b1;
    end else begin
      state   <= state_d;
      clk_cnt <= clk_cnt_d;
      bit_idx <= bit_idx_d;
      shreg   <= shreg_d;
      tx      <= tx_d;
    end
  end

endmodule

// File: rtl/uart_temp_sens.sv
// Measures PWM low-phase width in clk cycles and reports the latest value
// as a 3-byte UART frame {A5, value[11:8], value[7:0]}.
module uart_temp_sens
  import uart_temp_sens_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int COUNT_W      = COUNT_W_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic               s1, s2, s3;
  logic               fall, rise, rise_q;
  logic [COUNT_W-1:0] cnt, result, frame_buf;
  logic               pending;
  logic [1:0]         byte_idx;
  logic [11:0]        frame_val;
  logic               frame_go, next_byte;
  logic               tx_start, tx, tx_busy, tx_done;
  logic [7:0]         tx_data;
  logic               unused_ok;

  assign unused_ok = &{1'b0, ena, ui_in[7:1], uio_in};

  assign fall = ~s2 & s3;
  assign rise = s2 & ~s3;

  assign frame_val = 12'(frame_buf);
  assign frame_go  = pending & ~tx_busy;
  assign next_byte = tx_done & (byte_idx < 2'(FRAME_BYTES - 1));
  assign tx_start  = frame_go | next_byte;
  assign tx_data   = frame_go ? SYNC_BYTE : frame_byte(byte_idx + 2'd1, frame_val);

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it only takes effect on a clock edge.
    if (rst) begin
      s1        <= 1'b1;
      s2        <= 1'b1;
      s3        <= 1'b1;
      rise_q    <= 1'b0;
      cnt       <= '0;
      result    <= '0;
      pending   <= 1'b0;
      frame_buf <= '0;
      byte_idx  <= 2'd0;
    end else begin
      s1     <= ui_in[0];
      s2     <= s1;
      s3     <= s2;
      rise_q <= rise;

      if (fall)                        cnt <= COUNT_W'(1);
      else if (!s2 && cnt != '1)       cnt <= cnt + 1'b1;

      // A capture in the frame-start cycle wins over the clear, so the
      // new value stays pending for the following frame.
      if (rise_q) begin
        result  <= cnt;
        pending <= 1'b1;
      end else if (frame_go) begin
        pending <= 1'b0;
      end

      if (frame_go) begin
        frame_buf <= result;
        byte_idx  <= 2'd0;
      end else if (next_byte) begin
        byte_idx  <= byte_idx + 2'd1;
      end
    end
  end

  uart_tx_8n1 #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk  (clk),
    .rst  (rst),
    .start(tx_start),
    .data (tx_data),
    .tx   (tx),
    .busy (tx_busy),
    .done (tx_done)
  );

  assign uo_out  = {5'b00000, s2, tx_busy, tx};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_uart_temp_sens.sv
// Self-checking bench: a UART line decoder turns TX back into bytes, which
// are compared with the widths of the PWM pulses driven onto ui_in[0].
`timescale 1ns/1ps
module tb_uart_temp_sens;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h01;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] rx_q[$];
  int         mon_cnt = 0;
  bit         mon_active = 1'b0;
  logic [7:0] mon_byte = 8'h00;
  int         busy_run = 0;
  int         last_busy = 0;
  bit         busy_seen = 1'b0;

  always #10 clk = ~clk;

  uart_temp_sens #(
    .CLKS_PER_BIT(CPB),
    .COUNT_W     (12)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Line decoder: samples each bit near its middle, aborts on reset.
  always @(negedge clk) begin
    if (rst) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (uo_out[0] == 1'b0) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
      end
    end else begin
      mon_cnt++;
      if ((mon_cnt % CPB) == CPB / 2) begin
        if (mon_cnt / CPB == 0) begin
          check("start_bit", uo_out[0], 0);
        end else if (mon_cnt / CPB <= 8) begin
          mon_byte[mon_cnt / CPB - 1] = uo_out[0];
        end else begin
          check("stop_bit", uo_out[0], 1);
          rx_q.push_back(mon_byte);
          mon_active = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      busy_run = 0;
    end else if (uo_out[1]) begin
      busy_run++;
      busy_seen = 1'b1;
    end else if (busy_run != 0) begin
      last_busy = busy_run;
      busy_run  = 0;
    end
  end

  initial begin
    #(20ns * 150_000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // All tasks start and end 1 ns after a rising edge.
  task automatic do_reset();
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    rx_q.delete();
    busy_seen = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_pulse(input int low, input int high);
    if (low > 0) begin
      ui_in[0] = 1'b0;
      cycles(low);
    end
    ui_in[0] = 1'b1;
    cycles(high);
  endtask

  task automatic wait_bytes(input string tag, input int n, input int budget);
    int t = 0;
    while (rx_q.size() < n && t < budget) begin
      cycles(1);
      t++;
    end
    check(tag, rx_q.size(), n);
  endtask

  task automatic check_frame(input string tag, input int value);
    int exp_v;
    exp_v = (value > 4095) ? 4095 : value;
    if (rx_q.size() >= 3) begin
      check({tag, "_sync"}, rx_q.pop_front(), 8'hA5);
      check({tag, "_hi"},   rx_q.pop_front(), exp_v >> 8);
      check({tag, "_lo"},   rx_q.pop_front(), exp_v & 8'hFF);
    end
  endtask

  task automatic wait_quiet(input int budget);
    int t = 0;
    while (uo_out[1] && t < budget) begin
      cycles(1);
      t++;
    end
    check("quiet_busy", uo_out[1], 0);
  endtask

  initial begin
    int k;
    int ptr;
    int nframes;
    int v;
    bit found;
    int stress_w[$];
    logic [7:0] b0, b1, b2;

    // Reset state and quiet line.
    do_reset();
    check("reset_uo_out", uo_out, 8'h05);
    check("reset_uio_out", uio_out, 8'h00);
    check("reset_uio_oe", uio_oe, 8'h00);
    cycles(1000);
    check("reset_no_frame", rx_q.size(), 0);
    check("reset_no_busy", busy_seen, 0);

    // Single pulse: latency, content, busy length, no resend.
    do_reset();
    ui_in[0] = 1'b0;
    cycles(100);
    ui_in[0] = 1'b1;
    k = 0;
    do begin
      cycles(1);
      k++;
    end while (uo_out[0] != 1'b0 && k < 20);
    check("frame_latency", k, 5);
    wait_bytes("single_bytes", 3, 40 * CPB);
    check_frame("single", 100);
    cycles(20);
    check("busy_len", last_busy, 30 * CPB);
    cycles(1000);
    check("single_no_repeat", rx_q.size(), 0);

    // Mid-range and saturating widths.
    do_reset();
    drive_pulse(3000, 25);
    wait_bytes("mid_bytes", 3, 40 * CPB);
    check_frame("mid", 3000);
    do_reset();
    drive_pulse(5000, 25);
    wait_bytes("sat_bytes", 3, 40 * CPB);
    check_frame("sat", 5000);
    cycles(600);
    check("sat_no_repeat", rx_q.size(), 0);

    // Latest wins: both later pulses land while the first frame is in flight.
    do_reset();
    drive_pulse(200, 25);
    drive_pulse(100, 25);
    drive_pulse(150, 25);
    wait_bytes("latest_bytes", 6, 2000);
    check_frame("latest_first", 200);
    check_frame("latest_second", 150);
    cycles(600);
    check("latest_dropped", rx_q.size(), 0);

    // Reset during the second byte abandons the frame.
    do_reset();
    drive_pulse(300, 5);
    k = 0;
    while (!uo_out[1] && k < 100) begin
      cycles(1);
      k++;
    end
    check("rstmid_frame_started", uo_out[1], 1);
    cycles(10 * CPB + 4);
    check("rstmid_in_start_bit", uo_out[0], 0);
    rst = 1'b1;
    cycles(1);
    check("rstmid_tx_high", uo_out[0], 1);
    check("rstmid_busy_low", uo_out[1], 0);
    cycles(1);
    rst = 1'b0;
    rx_q.delete();
    busy_seen = 1'b0;
    cycles(1000);
    check("rstmid_no_frame", rx_q.size(), 0);
    check("rstmid_no_busy", busy_seen, 0);

    // Random stress: every frame is a driven width, in driving order.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(2047, 0);
      drive_pulse(k, 25);
      if (k > 0) stress_w.push_back(k);
    end
    cycles(1200);
    wait_quiet(2000);
    cycles(CPB);
    check("stress_whole_frames", rx_q.size() % 3, 0);
    nframes = rx_q.size() / 3;
    check("stress_frames_nonzero", (nframes > 0), 1);
    ptr = 0;
    v   = -1;
    for (int f = 0; f < nframes; f++) begin
      b0 = rx_q.pop_front();
      b1 = rx_q.pop_front();
      b2 = rx_q.pop_front();
      check("stress_sync", b0, 8'hA5);
      check("stress_hi_zero", b1[7:4], 0);
      v = {b1[3:0], b2};
      found = 1'b0;
      for (int j = ptr; j < stress_w.size() && !found; j++) begin
        if (stress_w[j] == v) begin
          found = 1'b1;
          ptr   = j + 1;
        end
      end
      check("stress_value_known", found, 1);
    end
    if (stress_w.size() > 0 && nframes > 0) check("stress_last_value", v, stress_w[$]);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
